// File: rtl/saturn_ins_issue.sv
// Nibble-serial Saturn instruction front-end: decodes P=n, D0=/D1=, LC(n), GOTO
// and issues them to saturn_alu. Optional counters under SATURN_ISSUE_PERF_EN.
module saturn_ins_issue #(
    parameter int IMM_MAX = 16,
    parameter int PTR_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_nibble,
    input  logic        i_nibble_valid,
    output logic        o_nibble_ready,
    input  logic [3:0]  i_reg_p,
    output logic        o_ins_decoded,
    output logic        o_ins_alu_op,
    output logic [4:0]  o_alu_op,
    output logic [4:0]  o_reg_dest,
    output logic [4:0]  o_reg_src1,
    output logic [4:0]  o_reg_src2,
    output logic [3:0]  o_field_start,
    output logic [3:0]  o_field_last,
    output logic [3:0]  o_imm_value,
    output logic        o_alu_no_stall,
    input  logic        i_alu_accept,
    input  logic        i_alu_step,
    input  logic        i_alu_stall_dec,
`ifdef SATURN_ISSUE_PERF_EN
    output logic [15:0] o_stall_cycles,
    output logic [15:0] o_ins_count,
`endif
    output logic        o_illegal
);

    // Encodings shared with def-alu.v
    localparam logic [4:0] ALU_OP_COPY     = 5'd1;
    localparam logic [4:0] ALU_OP_JMP_REL3 = 5'd27;
    localparam logic [4:0] ALU_REG_C       = 5'd2;
    localparam logic [4:0] ALU_REG_D0      = 5'd4;
    localparam logic [4:0] ALU_REG_D1      = 5'd5;
    localparam logic [4:0] ALU_REG_P       = 5'd17;
    localparam logic [4:0] ALU_REG_IMM     = 5'd19;

    // state   | meaning
    // S_IDLE  | waiting for first opcode nibble
    // S_OP2   | second nibble of 1x (D0=/D1= load)
    // S_LCX   | LC count nibble
    // S_IMM   | collecting immediate nibbles
    // S_ISSUE | instruction presented, waiting for ALU accept
    // S_RUN   | ALU consuming one immediate nibble per step
    typedef enum logic [2:0] {
        S_IDLE, S_OP2, S_LCX, S_IMM, S_ISSUE, S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] len_m1_q, len_m1_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [4:0]       op_q, op_d;
    logic [4:0]       dest_q, dest_d;
    logic [4:0]       src1_q, src1_d;
    logic [3:0]       fstart_q, fstart_d;
    logic [3:0]       flast_q, flast_d;
    logic             pend_q, pend_d;
    logic             decoded_q, decoded_d;
    logic             illegal_q, illegal_d;
    logic             buf_we;
    logic             hs;
    logic [3:0]       imm_buf_q [IMM_MAX];

    assign o_nibble_ready = (state_q == S_IDLE) || (state_q == S_OP2) ||
                            (state_q == S_LCX)  || (state_q == S_IMM);
    assign hs = i_nibble_valid && o_nibble_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            len_m1_q  <= '0;
            wp_q      <= '0;
            sp_q      <= '0;
            op_q      <= '0;
            dest_q    <= '0;
            src1_q    <= '0;
            fstart_q  <= '0;
            flast_q   <= '0;
            pend_q    <= 1'b0;
            decoded_q <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < IMM_MAX; i++) imm_buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            len_m1_q  <= len_m1_d;
            wp_q      <= wp_d;
            sp_q      <= sp_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            src1_q    <= src1_d;
            fstart_q  <= fstart_d;
            flast_q   <= flast_d;
            pend_q    <= pend_d;
            decoded_q <= decoded_d;
            illegal_q <= illegal_d;
            if (buf_we) imm_buf_q[wp_q] <= i_nibble;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_m1_d  = len_m1_q;
        wp_d      = wp_q;
        sp_d      = sp_q;
        op_d      = op_q;
        dest_d    = dest_q;
        src1_d    = src1_q;
        fstart_d  = fstart_q;
        flast_d   = flast_q;
        pend_d    = pend_q;
        decoded_d = 1'b0;
        illegal_d = 1'b0;
        buf_we    = 1'b0;
        case (state_q)
            S_IDLE: if (hs) begin
                case (i_nibble)
                    4'h1: state_d = S_OP2;
                    4'h3: state_d = S_LCX;
                    4'h2: begin
                        state_d  = S_IMM;
                        len_m1_d = '0;
                        op_d     = ALU_OP_COPY;
                        dest_d   = ALU_REG_P;
                        src1_d   = ALU_REG_IMM;
                        fstart_d = 4'h0;
                        flast_d  = 4'h0;
                        wp_d     = '0;
                    end
                    4'h6: begin
                        state_d  = S_IMM;
                        len_m1_d = PTR_W'(2);
                        op_d     = ALU_OP_JMP_REL3;
                        dest_d   = 5'd0;
                        src1_d   = ALU_REG_IMM;
                        fstart_d = 4'h0;
                        flast_d  = 4'h2;
                        wp_d     = '0;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            S_OP2: if (hs) begin
                state_d  = S_IMM;
                op_d     = ALU_OP_COPY;
                src1_d   = ALU_REG_IMM;
                fstart_d = 4'h0;
                wp_d     = '0;
                dest_d   = i_nibble[2] ? ALU_REG_D1 : ALU_REG_D0;
                case (i_nibble)
                    4'h9, 4'hD: begin len_m1_d = PTR_W'(1); flast_d = 4'h1; end
                    4'hA, 4'hE: begin len_m1_d = PTR_W'(3); flast_d = 4'h3; end
                    4'hB, 4'hF: begin len_m1_d = PTR_W'(4); flast_d = 4'h4; end
                    default: begin
                        state_d   = S_IDLE;
                        illegal_d = 1'b1;
                        op_d      = '0;
                        dest_d    = '0;
                        src1_d    = '0;
                        flast_d   = '0;
                    end
                endcase
            end
            S_LCX: if (hs) begin
                if (IMM_MAX < 16 && int'(i_nibble) >= IMM_MAX) begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end else begin
                    state_d  = S_IMM;
                    len_m1_d = PTR_W'(i_nibble);
                    op_d     = ALU_OP_COPY;
                    dest_d   = ALU_REG_C;
                    src1_d   = ALU_REG_IMM;
                    fstart_d = i_reg_p;
                    flast_d  = i_reg_p + i_nibble;
                    wp_d     = '0;
                end
            end
            S_IMM: if (hs) begin
                buf_we = 1'b1;
                if (wp_q == len_m1_q) begin
                    state_d   = S_ISSUE;
                    decoded_d = 1'b1;
                    pend_d    = 1'b1;
                end else begin
                    wp_d = wp_q + PTR_W'(1);
                end
            end
            // accept has priority; a simultaneous step belongs to the init cycle
            S_ISSUE: if (i_alu_accept) begin
                state_d = S_RUN;
                pend_d  = 1'b0;
                sp_d    = '0;
            end
            S_RUN: if (i_alu_step) begin
                if (sp_q == len_m1_q) begin
                    state_d  = S_IDLE;
                    op_d     = '0;
                    dest_d   = '0;
                    src1_d   = '0;
                    fstart_d = '0;
                    flast_d  = '0;
                end else begin
                    sp_d = sp_q + PTR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_imm_value = 4'h0;
        if (state_q == S_ISSUE)    o_imm_value = imm_buf_q[0];
        else if (state_q == S_RUN) o_imm_value = imm_buf_q[sp_q];
    end

    assign o_ins_decoded  = decoded_q;
    assign o_ins_alu_op   = pend_q;
    assign o_alu_op       = op_q;
    assign o_reg_dest     = dest_q;
    assign o_reg_src1     = src1_q;
    assign o_reg_src2     = 5'd0;
    assign o_field_start  = fstart_q;
    assign o_field_last   = flast_q;
    assign o_alu_no_stall = 1'b0;
    assign o_illegal      = illegal_q;

`ifdef SATURN_ISSUE_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] icount_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_q  <= '0;
            icount_q <= '0;
        end else begin
            if ((state_q == S_ISSUE || state_q == S_RUN) && i_alu_stall_dec &&
                stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (decoded_q) icount_q <= icount_q + 16'd1;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_ins_count    = icount_q;
`else
    logic unused_stall;
    assign unused_stall = i_alu_stall_dec;
`endif

endmodule

// File: doc/saturn_ins_issue.md
Name: saturn_ins_issue

Overview:
- Nibble-serial instruction front-end and the issuing end of the ALU control interface.
- Collects opcode and immediate nibbles from the fetch path and decodes a subset of the Saturn instruction set: P=n, D0=(2/4/5), D1=(2/4/5), LC(n) and GOTO rel3.
- Drives op, dest, src, field and immediate lines to saturn_alu, holding them until the ALU latches the instruction.
- Serves immediate nibbles one per ALU step until the field is exhausted.

Parameters:
- IMM_MAX, 16, depth of the immediate nibble buffer (max nibbles per instruction).
- PTR_W, 4, width of the buffer and step pointers; must satisfy 2^PTR_W >= IMM_MAX.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_nibble  in  4  next instruction nibble from fetch.
- i_nibble_valid  in  1  i_nibble is valid this cycle.
- o_nibble_ready  out  1  block consumes i_nibble this cycle when valid.
- i_reg_p  in  4  current P register, used for the LC field start.
- o_ins_decoded  out  1  one-cycle pulse when an instruction completes decode.
- o_ins_alu_op  out  1  ALU instruction pending; fields valid and stable.
- o_alu_op  out  5  ALU_OP_* code from def-alu.v.
- o_reg_dest  out  5  ALU_REG_* destination.
- o_reg_src1  out  5  ALU_REG_* source; always ALU_REG_IMM for this subset.
- o_reg_src2  out  5  fixed 0.
- o_field_start  out  4  first field nibble.
- o_field_last  out  4  last field nibble.
- o_imm_value  out  4  immediate nibble for the current ALU step.
- o_alu_no_stall  out  1  fixed 0.
- i_alu_accept  in  1  ALU latched the instruction (its init cycle).
- i_alu_step  in  1  ALU saved one nibble (its save cycle while running).
- i_alu_stall_dec  in  1  ALU stall indication.
- o_illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset values: state IDLE, o_nibble_ready=1, and every other output 0; buffer and pointers cleared.
- Reset mid-instruction abandons it; no partial issue survives.
- The FSM advances only on i_nibble_valid && o_nibble_ready. o_nibble_ready=1 only in IDLE, OP2, LCX and IMM.
- IDLE:
  - 2 goes to IMM with len 1: dest P, field 0..0.
  - 3 goes to LCX.
  - 1 goes to OP2.
  - 6 goes to IMM with len 3: op ALU_OP_JMP_REL3, dest 0, field 0..2.
  - Any other nibble pulses o_illegal and stays in IDLE.
- OP2, dest D0:
  - 9 gives len 2, field 0..1.
  - A gives len 4, field 0..3.
  - B gives len 5, field 0..4.
- OP2, dest D1:
  - D gives len 2, field 0..1.
  - E gives len 4, field 0..3.
  - F gives len 5, field 0..4.
- OP2, any other nibble: pulse o_illegal and return to IDLE.
- LCX: nibble x sets len=x+1, dest C, field start=i_reg_p sampled this cycle, last=(i_reg_p+x) mod 16 (wraps 15 to 0). Next state IMM.
- Op codes: all non-GOTO instructions use ALU_OP_COPY, src1 ALU_REG_IMM.
- IMM: store nibbles in arrival order into buf[0..len-1], least significant first. After the len-th nibble, pulse o_ins_decoded, assert o_ins_alu_op, go to ISSUE. One cycle after the final nibble handshake, o_ins_decoded=1.
- ISSUE: all field and op outputs held stable, o_imm_value=buf[0]. On i_alu_accept, clear o_ins_alu_op, set step pointer sp=0, go to RUN. Without accept, wait indefinitely.
- RUN: o_imm_value=buf[sp]. Each i_alu_step increments sp. The step with sp==len-1 returns to IDLE and clears o_alu_op/dest/fields to 0.
- i_alu_step outside RUN is ignored. i_alu_accept outside ISSUE is ignored.
- i_alu_accept and i_alu_step in the same cycle in ISSUE: accept only; the step is ignored.
- A new instruction never starts until RUN ends, so at most one instruction is in flight.
- len never exceeds IMM_MAX. With IMM_MAX<16, LC x>=IMM_MAX pulses o_illegal and returns to IDLE.

Optional Feature:
- Macro: SATURN_ISSUE_PERF_EN.
- Defined: adds output o_stall_cycles (16 bits, reset 0). It increments every cycle in ISSUE or RUN while i_alu_stall_dec=1, saturating at FFFF, and adds o_ins_count (16 bits), +1 per o_ins_decoded, wrapping.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Nibbles 2,7 -> o_ins_decoded pulse; op COPY, dest P, field 0..0, imm 7; accept then 1 step -> IDLE, o_nibble_ready=1.
- Nibbles 1,B,5,4,3,2,1 -> dest D0, field 0..4; steps give o_imm_value 5,4,3,2,1 in order; ready low from issue until the last step.
- i_reg_p=E, nibbles 3,2,A,B,C -> dest C, start E, last 0 (wrap); imm sequence A,B,C.
- Nibbles 6,1,2,3 -> op JMP_REL3, field 0..2; hold i_alu_accept low 10 cycles -> outputs stable, no new nibble consumed.
- Nibble 5 -> o_illegal pulse, state IDLE; then nibbles 1,C -> o_illegal pulse.
- Assert i_reset_n low during RUN of D1=(5) -> all outputs 0, o_nibble_ready=1; with SATURN_ISSUE_PERF_EN, 4 stalled cycles -> o_stall_cycles=4.
